mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-port arbiter that shares one single-ported memory controller between
//   the instruction-fetch (IF) port and the data (MEM) port. A request is
//   granted from IDLE. Its address, write data and direction are then latched
//   and held on ext_* until ext_ack arrives. The arbiter returns to IDLE after
//   every transaction, so back-to-back transactions are separated by one idle
//   cycle.
//
//   Build option:
//     MEM_ARB_STARVE_GUARD_EN -- when defined, IF is forced through after
//       STARVE_LIMIT consecutive MEM grants made while IF was waiting. When
//       undefined, MEM always has strict priority over IF.
//
//   Ports:
//     clk, rst              clock; asynchronous active-high reset
//     if_req, if_addr       IF read request (held until if_done)
//     if_rdata, if_done     IF read data / one-cycle completion strobe
//     if_stall              IF request outstanding and not completing
//     mem_rd, mem_wr        MEM read/write request (both set = write)
//     mem_addr, mem_wdata   MEM address / write data
//     mem_rdata, mem_done   MEM read data / one-cycle completion strobe
//     mem_stall             MEM request outstanding and not completing
//     ext_req, ext_we       controller request / write enable
//     ext_addr, ext_wdata   latched address / write data of the granted access
//     ext_rdata, ext_ack    controller read data / completion
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        mem_stall,
    output logic        ext_req,
    output logic        ext_we,
    output logic [31:0] ext_addr,
    output logic [31:0] ext_wdata,
    input  logic [31:0] ext_rdata,
    input  logic        ext_ack
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SERVE_MEM = 2'd1;
    localparam logic [1:0] SERVE_IF  = 2'd2;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : gBadStarveLimit
        $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
    end

    logic [1:0] state;
    logic       memReq;
    logic       grantIf;
    logic       grantMem;

    assign memReq = mem_rd | mem_wr;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starveCnt;
    logic       starved;

    assign starved = (starveCnt == LIMIT);
    assign grantIf = if_req & (~memReq | starved);

    // Counts MEM grants taken while IF was waiting. Any IF grant, or a MEM
    // grant with nobody waiting on IF, starts the count over. The counter
    // cannot pass LIMIT: at LIMIT with IF waiting, IF wins and clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starveCnt <= '0;
        end else if (state == IDLE) begin
            if (grantIf) begin
                starveCnt <= '0;
            end else if (grantMem) begin
                starveCnt <= if_req ? starveCnt + 4'd1 : 4'd0;
            end
        end
    end
`else
    assign grantIf = if_req & ~memReq;
`endif

    assign grantMem = memReq & ~grantIf;

    // Grant and latch the transaction in IDLE. While serving, the ext_*
    // registers are held, so requester inputs may change freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ext_we    <= 1'b0;
            ext_addr  <= '0;
            ext_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantIf) begin
                        state     <= SERVE_IF;
                        ext_we    <= 1'b0;
                        ext_addr  <= if_addr;
                        ext_wdata <= '0;
                    end else if (grantMem) begin
                        state     <= SERVE_MEM;
                        ext_we    <= mem_wr;  // rd+wr together is a write
                        ext_addr  <= mem_addr;
                        ext_wdata <= mem_wdata;
                    end
                end
                SERVE_MEM, SERVE_IF: begin
                    if (ext_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The done strobes come straight from state and ext_ack. A reset clears
    // state asynchronously, so it also suppresses a done in that same cycle.
    assign ext_req   = (state == SERVE_MEM) || (state == SERVE_IF);
    assign if_done   = (state == SERVE_IF) & ext_ack;
    assign mem_done  = (state == SERVE_MEM) & ext_ack;
    assign if_rdata  = if_done ? ext_rdata : '0;
    assign mem_rdata = mem_done ? ext_rdata : '0;
    assign if_stall  = if_req & ~if_done;
    assign mem_stall = memReq & ~mem_done;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_stall;
    logic        ext_req;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [31:0] ext_rdata;
    logic        ext_ack;

    int checkCnt = 0;
    int failCnt  = 0;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    mem_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .if_stall  (if_stall),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .mem_stall (mem_stall),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_rdata (ext_rdata),
        .ext_ack   (ext_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        if (obs !== exp) begin
            failCnt++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Entered at a falling edge with the arbiter idle and the requests
    // already driven. Checks the grant on the next cycle, perturbs the served
    // requester's inputs, waits ackDelay serve cycles, then acks. Returns at
    // the falling edge after the ack (arbiter idle again).
    task automatic serveOne(input string tag, input bit expIf, input logic [31:0] expAddr,
                            input bit expWe, input logic [31:0] expWdata, input int ackDelay,
                            input logic [31:0] rd, input logic [31:0] midAddr);
        #1;
        checkVal({tag, ".idle"}, 32'(ext_req), 32'd0);
        @(negedge clk); #1;
        checkVal({tag, ".req"}, 32'(ext_req), 32'd1);
        checkVal({tag, ".addr"}, ext_addr, expAddr);
        checkVal({tag, ".we"}, 32'(ext_we), 32'(expWe));
        if (expWe) checkVal({tag, ".wdata"}, ext_wdata, expWdata);
        checkVal({tag, ".stall"}, 32'(expIf ? if_stall : mem_stall), 32'd1);
        if (expIf) begin
            if_addr = midAddr;
        end else begin
            mem_addr  = midAddr;
            mem_wdata = ~mem_wdata;
        end
        for (int i = 0; i < ackDelay; i++) begin
            checkVal({tag, ".waitDone"}, 32'({if_done, mem_done}), 32'd0);
            @(negedge clk); #1;
            checkVal({tag, ".heldAddr"}, ext_addr, expAddr);
            if (expWe) checkVal({tag, ".heldWdata"}, ext_wdata, expWdata);
        end
        ext_ack   = 1'b1;
        ext_rdata = rd;
        #1;
        checkVal({tag, ".ackAddr"}, ext_addr, expAddr);
        if (expIf) begin
            checkVal({tag, ".ifDone"}, 32'(if_done), 32'd1);
            checkVal({tag, ".ifRdata"}, if_rdata, rd);
            checkVal({tag, ".memQuiet"}, {31'd0, mem_done} | mem_rdata, 32'd0);
            checkVal({tag, ".ifStall"}, 32'(if_stall), 32'd0);
        end else begin
            checkVal({tag, ".memDone"}, 32'(mem_done), 32'd1);
            checkVal({tag, ".memRdata"}, mem_rdata, rd);
            checkVal({tag, ".ifQuiet"}, {31'd0, if_done} | if_rdata, 32'd0);
            checkVal({tag, ".memStall"}, 32'(mem_stall), 32'd0);
        end
        @(negedge clk);
        ext_ack   = 1'b0;
        ext_rdata = '0;
    endtask

    initial begin
        rst       = 1'b1;
        if_req    = 1'b1;
        if_addr   = 32'h0000_0AAA;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ext_ack   = 1'b1;
        ext_rdata = 32'h0000_1234;

        // Reset state, with a request and a stray ack present
        @(negedge clk); @(negedge clk); #1;
        checkVal("rst.req", 32'(ext_req), 32'd0);
        checkVal("rst.we", 32'(ext_we), 32'd0);
        checkVal("rst.addr", ext_addr, 32'd0);
        checkVal("rst.wdata", ext_wdata, 32'd0);
        checkVal("rst.done", 32'({if_done, mem_done}), 32'd0);
        checkVal("rst.rdata", if_rdata | mem_rdata, 32'd0);

        // IF read only
        @(negedge clk);
        rst       = 1'b0;
        ext_ack   = 1'b0;
        ext_rdata = '0;
        if_addr   = 32'h0000_0100;
        serveOne("ifRead", 1'b1, 32'h100, 1'b0, 32'h0, 0, 32'hDEADBEEF, 32'h100);
        if_req = 1'b0;
        #1;
        checkVal("ifRead.onePulse", 32'({if_done, mem_done}), 32'd0);

        // Simultaneous IF and MEM write: MEM first, then IF
        @(negedge clk);
        if_req    = 1'b1;
        if_addr   = 32'h0000_0104;
        mem_wr    = 1'b1;
        mem_addr  = 32'h0000_0200;
        mem_wdata = 32'h0000_0055;
        serveOne("simMem", 1'b0, 32'h200, 1'b1, 32'h55, 0, 32'h0000_A5A5, 32'h200);
        mem_wr = 1'b0;
        serveOne("simIf", 1'b1, 32'h104, 1'b0, 32'h0, 0, 32'h1111_2222, 32'h104);
        if_req = 1'b0;

        // Read and write together count as a write
        mem_rd    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = 32'h0000_0208;
        mem_wdata = 32'h0000_0077;
        serveOne("rdwr", 1'b0, 32'h208, 1'b1, 32'h77, 1, 32'h0, 32'h20C);
        mem_wr = 1'b0;

        // Held address over a slow ack
        mem_addr = 32'h0000_0300;
        serveOne("held", 1'b0, 32'h300, 1'b0, 32'h0, 5, 32'hCAFE_0001, 32'h400);
        mem_rd = 1'b0;
        #1;
        checkVal("held.onePulse", 32'({if_done, mem_done}), 32'd0);
        @(negedge clk); #1;
        checkVal("held.idleAfter", 32'(ext_req), 32'd0);

        // Request dropped mid-transaction still completes
        mem_rd   = 1'b1;
        mem_addr = 32'h0000_0500;
        @(negedge clk); #1;
        checkVal("drop.req", 32'(ext_req), 32'd1);
        checkVal("drop.addr", ext_addr, 32'h500);
        mem_rd = 1'b0;
        @(negedge clk);
        ext_ack   = 1'b1;
        ext_rdata = 32'h0000_0099;
        #1;
        checkVal("drop.done", 32'(mem_done), 32'd1);
        checkVal("drop.rdata", mem_rdata, 32'h99);
        @(negedge clk);
        ext_ack   = 1'b0;
        ext_rdata = '0;
        #1;
        checkVal("drop.idle", 32'({ext_req, mem_done}), 32'd0);

        // Starvation: MEM requests continuously while IF waits
        @(negedge clk);
        if_req = 1'b1;
        mem_rd = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bit expIf;
            logic [31:0] expAddr;
            expIf   = GUARD && (k % 3 == 2);
            expAddr = expIf ? 32'h700 : 32'h600;
            if_addr  = 32'h0000_0700;
            mem_addr = 32'h0000_0600;
            serveOne($sformatf("starve%0d", k), expIf, expAddr, 1'b0, 32'h0, 0,
                     32'h1000 + 32'(k), expAddr);
        end

        // Reset during SERVE_IF before ack abandons it
        mem_rd  = 1'b0;
        if_addr = 32'h0000_0800;
        @(negedge clk); #1;
        checkVal("rstMid.req", 32'(ext_req), 32'd1);
        checkVal("rstMid.addr", ext_addr, 32'h800);
        rst       = 1'b1;
        ext_ack   = 1'b1;
        ext_rdata = 32'h0000_0005;
        #1;
        checkVal("rstMid.reqDrop", 32'(ext_req), 32'd0);
        checkVal("rstMid.noDone", 32'(if_done), 32'd0);
        checkVal("rstMid.rdata", if_rdata, 32'd0);
        checkVal("rstMid.addrClr", ext_addr, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        ext_ack   = 1'b0;
        ext_rdata = '0;
        serveOne("rstRegrant", 1'b1, 32'h800, 1'b0, 32'h0, 0, 32'h0000_ABCD, 32'h800);
        if_req = 1'b0;
        #1;
        checkVal("end.done", 32'({if_done, mem_done}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
        $finish;
    end

endmodule
